// File: rtl/sync_debounce.sv
// sync_debounce: multi-flop synchroniser followed by an enable-qualified
// debounce FSM.
//
// The raw pin is synchronised through SYNC_STAGES flops. A new level is
// accepted only after it has been seen on DEBOUNCE_CYCLES consecutive
// enabled cycles. q is a registered output.
//
// Build option:
//   SYNC_DEBOUNCE_EDGE_EN  defined   -> rise/fall/glitch are registered
//                                       one-cycle pulses
//   SYNC_DEBOUNCE_EDGE_EN  undefined -> rise/fall/glitch are tied to 0 and
//                                       no flops exist for them
// q timing is identical in both builds.
//
// state     | meaning
// ----------+---------------------------------------------------------
// STABLE_LO | accepted level is 0, no change pending
// WAIT_HI   | s is 1, counting enabled cycles before accepting 1
// STABLE_HI | accepted level is 1, no change pending
// WAIT_LO   | s is 0, counting enabled cycles before accepting 0

module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic data,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    // cnt reaching this value on a matching enabled cycle completes the wait
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // a single accepted cycle needs no WAIT state at all
    localparam bit              DIRECT   = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   q_r;
    logic                   q_nxt;

    // Synchroniser chain: shifts every clock, independent of en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counter and debounced level registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STABLE_LO;
            cnt   <= '0;
            q_r   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q_r   <= q_nxt;
        end
    end

    // Next-state and counter logic; everything holds while en is low.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (en) begin
            case (state)
                STABLE_LO: begin
                    if (s) begin
                        if (DIRECT) begin
                            state_nxt = STABLE_HI;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = WAIT_HI;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                WAIT_HI: begin
                    if (s) begin
                        if (cnt == CNT_LAST) begin
                            state_nxt = STABLE_HI;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        if (DIRECT) begin
                            state_nxt = STABLE_LO;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = WAIT_LO;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                WAIT_LO: begin
                    if (!s) begin
                        if (cnt == CNT_LAST) begin
                            state_nxt = STABLE_LO;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // q is 1 in the high stable state and while a pending fall is unconfirmed.
    always_comb begin
        q_nxt = (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);
    end

    assign q = q_r;

`ifdef SYNC_DEBOUNCE_EDGE_EN
    logic rise_r;
    logic fall_r;
    logic glitch_r;
    logic glitch_nxt;

    // A pending change is abandoned when s returns to the accepted level.
    always_comb begin
        glitch_nxt = en && (((state == WAIT_HI) && !s) ||
                            ((state == WAIT_LO) &&  s));
    end

    // Pulses line up with the cycle in which q first shows its new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
            glitch_r <= 1'b0;
        end else begin
            rise_r   <=  q_nxt & ~q_r;
            fall_r   <= ~q_nxt &  q_r;
            glitch_r <= glitch_nxt;
        end
    end

    assign rise   = rise_r;
    assign fall   = fall_r;
    assign glitch = glitch_r;
`else
    assign rise   = 1'b0;
    assign fall   = 1'b0;
    assign glitch = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce. Instance dut uses the default
// parameters (2 sync stages, 4 debounce cycles); dut1 uses 1 debounce cycle.
// Pulse expectations follow the SYNC_DEBOUNCE_EDGE_EN build setting.

module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic data;
    logic data1;
    logic en;
    logic q, rise, fall, glitch;
    logic q1, rise1, fall1, glitch1;

    int n_checks = 0;
    int n_fail   = 0;

    sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .data   (data),
        .en     (en),
        .q      (q),
        .rise   (rise),
        .fall   (fall),
        .glitch (glitch)
    );

    sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .data   (data1),
        .en     (en),
        .q      (q1),
        .rise   (rise1),
        .fall   (fall1),
        .glitch (glitch1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        data  = 1'b0;
        data1 = 1'b0;
        en    = 1'b0;

        // reset state
        #2;
        chk("rst_q", q, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);
        chk("rst_glitch", glitch, 1'b0);
        chk("rst_q1", q1, 1'b0);
        tick();
        tick();
        chk("rst_q_clocked", q, 1'b0);

        // clean edge: q and rise at edge 6
        reset = 1'b0;
        data  = 1'b1;
        en    = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("clean_q", q, e >= 6);
            chk("clean_rise", rise, (e == 6) & EDGE);
            chk("clean_fall", fall, 1'b0);
            chk("clean_glitch", glitch, 1'b0);
        end

        // asynchronous reset clears q immediately
        reset = 1'b1;
        data  = 1'b0;
        #1;
        chk("async_rst_q", q, 1'b0);
        chk("async_rst_rise", rise, 1'b0);
        tick();
        reset = 1'b0;

        // bounce: data high for 2 cycles then low; glitch after edge 5
        data = 1'b1;
        en   = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("bounce_q", q, 1'b0);
            chk("bounce_glitch", glitch, (e == 5) & EDGE);
            chk("bounce_rise", rise, 1'b0);
            chk("bounce_fall", fall, 1'b0);
            if (e == 2) data = 1'b0;
        end

        // back in STABLE_LO with a clear count: full latency again
        data = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("rerise_q", q, e == 6);
            chk("rerise_rise", rise, (e == 6) & EDGE);
        end

        // falling edge with the same latency
        data = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("fall_q", q, e < 6);
            chk("fall_fall", fall, (e == 6) & EDGE);
            chk("fall_rise", rise, 1'b0);
            chk("fall_glitch", glitch, 1'b0);
        end

        // enable gating: en high on odd edges only, q rises at edge 9
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data  = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            en = (e % 2 == 1);
            tick();
            chk("gate_q", q, e >= 9);
            chk("gate_rise", rise, (e == 9) & EDGE);
            chk("gate_glitch", glitch, 1'b0);
        end

        // reset mid-WAIT discards progress; full latency after release
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data  = 1'b1;
        en    = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("midrst_pre_q", q, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk("midrst_q", q, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("midrst_post_q", q, e == 6);
            chk("midrst_post_rise", rise, (e == 6) & EDGE);
        end

        // single-cycle debounce: q follows s directly, edge 3 latency
        reset = 1'b1;
        data  = 1'b0;
        data1 = 1'b1;
        tick();
        reset = 1'b0;
        en    = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("d1_rise_q", q1, e == 3);
            chk("d1_rise_rise", rise1, (e == 3) & EDGE);
        end
        data1 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("d1_fall_q", q1, e < 3);
            chk("d1_fall_fall", fall1, (e == 3) & EDGE);
            chk("d1_fall_glitch", glitch1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
